// File: rtl/kmeans_vga_pkg.sv
`default_nettype none
// =============================================================================
// kmeans_vga_pkg - shared raster constants, default palette, writer states
// Revision: 1.0
// =============================================================================
package kmeans_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int PIX_W    = 12;
  localparam int LABEL_W  = 3;
  localparam int ADDR_W   = 19;

  // RGB444 colours: black, red, green, blue, yellow, cyan, magenta, white
  localparam logic [PIX_W-1:0] DEFAULT_PAL [8] = '{
    12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  function automatic logic [PIX_W-1:0] pal_default(input int idx);
    logic [PIX_W-1:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      if (idx == i) c = DEFAULT_PAL[i];
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kmeans_palette.sv
`default_nettype none
// =============================================================================
// kmeans_palette - K-entry colour register file, one write port, async read
// Revision: 1.0
// =============================================================================
module kmeans_palette
  import kmeans_vga_pkg::*;
#(
  parameter int K       = 8,
  parameter int LABEL_W = kmeans_vga_pkg::LABEL_W,
  parameter int PIX_W   = kmeans_vga_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [LABEL_W-1:0] waddr,
  input  logic [PIX_W-1:0]   wdata,
  input  logic [LABEL_W-1:0] raddr,
  output logic [PIX_W-1:0]   rdata
);

  logic [PIX_W-1:0] mem_q [K];
  logic [PIX_W-1:0] mem_d [K];

  always_comb begin
    mem_d = mem_q;
    if (we && (32'(waddr) < K)) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++) mem_q[i] <= PIX_W'(pal_default(i));
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-write contents, so a same-cycle write affects later beats only
  assign rdata = (32'(raddr) < K) ? mem_q[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/kmeans_fb_writer.sv
`default_nettype none
// =============================================================================
// kmeans_fb_writer - label stream -> palette -> framebuffer port A writer
// Optional alignment grid overlay: KMEANS_FB_GRID_EN.  Revision: 1.0
// =============================================================================
module kmeans_fb_writer
  import kmeans_vga_pkg::*;
#(
  parameter int WIDTH   = H_ACTIVE,
  parameter int HEIGHT  = V_ACTIVE,
  parameter int K       = 8,
  parameter int LABEL_W = kmeans_vga_pkg::LABEL_W,
  parameter int PIX_W   = kmeans_vga_pkg::PIX_W,
  parameter int ADDR_W  = kmeans_vga_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [LABEL_W-1:0] s_label,
  input  logic               s_sof,
  input  logic               pal_we,
  input  logic [LABEL_W-1:0] pal_addr,
  input  logic [PIX_W-1:0]   pal_data,
  output logic               wea,
  output logic [ADDR_W-1:0]  addra,
  output logic [PIX_W-1:0]   dina,
  output logic               frame_done,
  output logic               busy,
  output logic               err_sof
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [XW-1:0]     LAST_X    = XW'(WIDTH - 1);

  wr_state_e          state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wea_q, wea_d;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic [PIX_W-1:0]   dina_q, dina_d;
  logic               frame_done_q, frame_done_d;
  logic               err_sof_q, err_sof_d;

  logic               accept;
  logic               write;
  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic [ADDR_W-1:0]  pix_addr;
  logic [PIX_W-1:0]   pix_colour;
  logic [PIX_W-1:0]   pal_rdata;

  kmeans_palette #(
    .K       (K),
    .LABEL_W (LABEL_W),
    .PIX_W   (PIX_W)
  ) u_palette (
    .clk   (clk),
    .rst   (rst),
    .we    (pal_we),
    .waddr (pal_addr),
    .wdata (pal_data),
    .raddr (s_label),
    .rdata (pal_rdata)
  );

  assign s_ready = (state_q != DONE);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    wea_d        = 1'b0;
    addra_d      = addra_q;
    dina_d       = dina_q;
    frame_done_d = 1'b0;
    err_sof_d    = 1'b0;
    write        = 1'b0;
    pix_x        = x_q;
    pix_y        = y_q;
    pix_addr     = addr_q;
    pix_colour   = pal_rdata;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_sof) begin
            write    = 1'b1;
            pix_x    = '0;
            pix_y    = '0;
            pix_addr = '0;
          end else begin
            err_sof_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (accept) begin
          write = 1'b1;
          // A fresh start-of-frame mid-frame resynchronises to pixel 0
          if (s_sof) begin
            pix_x     = '0;
            pix_y     = '0;
            pix_addr  = '0;
            err_sof_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef KMEANS_FB_GRID_EN
    if ((6'(pix_x) == 6'd0) || (6'(pix_y) == 6'd0)) pix_colour = '1;
`endif

    if (write) begin
      wea_d   = 1'b1;
      addra_d = pix_addr;
      dina_d  = pix_colour;
      if (pix_addr == LAST_ADDR) begin
        state_d      = DONE;
        frame_done_d = 1'b1;
        x_d          = '0;
        y_d          = '0;
        addr_d       = '0;
      end else begin
        state_d = WRITE;
        addr_d  = pix_addr + ADDR_W'(1);
        if (pix_x == LAST_X) begin
          x_d = '0;
          y_d = pix_y + YW'(1);
        end else begin
          x_d = pix_x + XW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      wea_q        <= 1'b0;
      addra_q      <= '0;
      dina_q       <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      wea_q        <= wea_d;
      addra_q      <= addra_d;
      dina_q       <= dina_d;
      frame_done_q <= frame_done_d;
      err_sof_q    <= err_sof_d;
    end
  end

  assign wea        = wea_q;
  assign addra      = addra_q;
  assign dina       = dina_q;
  assign frame_done = frame_done_q;
  assign err_sof    = err_sof_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_kmeans_fb_writer.sv
`default_nettype none
// =============================================================================
// tb_kmeans_fb_writer - vector table, directed corner cases and random stream
// Revision: 1.0
// =============================================================================
module tb_kmeans_fb_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int K  = 8;
  localparam int LW = 3;
  localparam int PW = 12;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [LW-1:0] s_label = '0;
  logic          s_sof = 1'b0;
  logic          pal_we = 1'b0;
  logic [LW-1:0] pal_addr = '0;
  logic [PW-1:0] pal_data = '0;
  logic          wea;
  logic [AW-1:0] addra;
  logic [PW-1:0] dina;
  logic          frame_done;
  logic          busy;
  logic          err_sof;

  always #5 clk = ~clk;

  kmeans_fb_writer #(
    .WIDTH (W), .HEIGHT (H), .K (K), .LABEL_W (LW), .PIX_W (PW), .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_label    (s_label),
    .s_sof      (s_sof),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .frame_done (frame_done),
    .busy       (busy),
    .err_sof    (err_sof)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [PW-1:0] def_pal [K];
  logic [PW-1:0] m_pal   [K];
  bit            m_in_frame;
  int            m_pix;
  bit            m_done;
  bit            m_wea, m_fd, m_err;
  int            m_addra;
  logic [PW-1:0] m_dina;

  function automatic logic [PW-1:0] gridify(input int idx, input logic [PW-1:0] c);
`ifdef KMEANS_FB_GRID_EN
    if (((idx % W) % 64 == 0) || ((idx / W) % 64 == 0)) return 12'hFFF;
`endif
    return c;
  endfunction

  task automatic model_reset();
    def_pal = '{12'h000, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};
    m_pal = def_pal;
    m_in_frame = 1'b0;
    m_pix = 0;
    m_done = 1'b0;
    m_wea = 1'b0; m_fd = 1'b0; m_err = 1'b0;
    m_addra = 0;
    m_dina = '0;
  endtask

  // Drive one cycle of inputs, predict, clock, then compare all outputs
  task automatic cycle(input bit v, input bit sof, input logic [LW-1:0] lab,
                       input bit pwe, input logic [LW-1:0] paddr, input logic [PW-1:0] pdata);
    bit acc, wr;
    int idx;
    logic [PW-1:0] c;
    s_valid = v; s_sof = sof; s_label = lab;
    pal_we = pwe; pal_addr = paddr; pal_data = pdata;
    check("s_ready", s_ready, !m_done);
    acc = v && !m_done;
    wr = 1'b0; idx = 0;
    m_wea = 1'b0; m_fd = 1'b0; m_err = 1'b0;
    if (acc) begin
      if (sof) begin
        wr = 1'b1; idx = 0; m_err = m_in_frame;
      end else if (m_in_frame) begin
        wr = 1'b1; idx = m_pix;
      end else begin
        m_err = 1'b1;
      end
    end
    if (wr) begin
      c = (int'(lab) < K) ? m_pal[lab] : 12'h000;
      m_wea = 1'b1;
      m_addra = idx;
      m_dina = gridify(idx, c);
      if (idx == N - 1) begin
        m_fd = 1'b1; m_in_frame = 1'b0; m_pix = 0;
      end else begin
        m_in_frame = 1'b1; m_pix = idx + 1;
      end
    end
    m_done = m_fd;
    if (pwe && int'(paddr) < K) m_pal[paddr] = pdata;
    @(posedge clk);
    #1;
    check("wea", wea, m_wea);
    check("addra", addra, m_addra);
    check("dina", dina, m_dina);
    check("frame_done", frame_done, m_fd);
    check("err_sof", err_sof, m_err);
    check("busy", busy, m_in_frame || m_done);
  endtask

  task automatic beat(input bit sof, input logic [LW-1:0] lab);
    cycle(1'b1, sof, lab, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_sof = 1'b0; pal_we = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    check("rst_dina", dina, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            v;
    bit            sof;
    logic [LW-1:0] lab;
    bit            exp_ready;
    bit            exp_wea;
    logic [AW-1:0] exp_addr;
    logic [PW-1:0] exp_dina;
    bit            exp_fd;
    bit            exp_err;
    bit            exp_busy;
  } vec_t;

  vec_t tbl [10];

  initial begin
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{v: 1'b1, sof: (i == 0), lab: LW'(i), exp_ready: 1'b1, exp_wea: 1'b1,
                 exp_addr: AW'(i), exp_dina: gridify(i, def_pal[i]), exp_fd: (i == 7),
                 exp_err: 1'b0, exp_busy: 1'b1};
    end
    // DONE cycle: beat is refused, outputs hold
    tbl[8] = '{v: 1'b1, sof: 1'b0, lab: 3'd0, exp_ready: 1'b0, exp_wea: 1'b0,
               exp_addr: AW'(7), exp_dina: gridify(7, 12'hFFF), exp_fd: 1'b0,
               exp_err: 1'b0, exp_busy: 1'b0};
    // Back in IDLE: beat without start-of-frame is a framing error
    tbl[9] = '{v: 1'b1, sof: 1'b0, lab: 3'd1, exp_ready: 1'b1, exp_wea: 1'b0,
               exp_addr: AW'(7), exp_dina: gridify(7, 12'hFFF), exp_fd: 1'b0,
               exp_err: 1'b1, exp_busy: 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tbl%0d_ready", i), s_ready, tbl[i].exp_ready);
      cycle(tbl[i].v, tbl[i].sof, tbl[i].lab, 1'b0, '0, '0);
      check($sformatf("tbl%0d_wea", i), wea, tbl[i].exp_wea);
      check($sformatf("tbl%0d_addra", i), addra, tbl[i].exp_addr);
      check($sformatf("tbl%0d_dina", i), dina, tbl[i].exp_dina);
      check($sformatf("tbl%0d_fd", i), frame_done, tbl[i].exp_fd);
      check($sformatf("tbl%0d_err", i), err_sof, tbl[i].exp_err);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // Mid-frame restart at address 5, then palette write racing a beat
    do_reset();
    beat(1'b1, 3'd0);
    for (int i = 1; i < 5; i++) beat(1'b0, 3'd1);
    beat(1'b1, 3'd3);
    check("restart_err", err_sof, 1);
    check("restart_addr", addra, 0);
    cycle(1'b1, 1'b0, 3'd2, 1'b1, 3'd2, 12'hABC);
    check("samecyc_addr", addra, 1);
    check("samecyc_err", err_sof, 0);
    check("samecyc_old_colour", dina, gridify(1, 12'h0F0));
    beat(1'b0, 3'd2);
    check("new_colour_addr", addra, 2);
    check("new_colour", dina, gridify(2, 12'hABC));
    beat(1'b0, 3'd5);
    check("pre_abort_addr", addra, 3);

    // Asynchronous abort with pixel 3 just written
    rst = 1'b1;
    #1;
    check("abort_wea", wea, 0);
    check("abort_addra", addra, 0);
    check("abort_dina", dina, 0);
    check("abort_fd", frame_done, 0);
    check("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    beat(1'b0, 3'd2);
    check("post_abort_needs_sof", err_sof, 1);
    beat(1'b1, 3'd2);
    check("post_abort_pal_default", dina, gridify(0, 12'h0F0));
    for (int i = 1; i < 6; i++) beat(1'b0, 3'd2);
    check("post_abort_addr5", addra, 5);
    check("post_abort_dina5", dina, gridify(5, 12'h0F0));

    // Randomised stream against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit v, sof, pwe;
      v   = ($urandom_range(0, 3) != 0);
      sof = m_in_frame ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
      pwe = ($urandom_range(0, 7) == 0);
      cycle(v, sof, LW'($urandom_range(0, K - 1)), pwe,
            LW'($urandom_range(0, K - 1)), PW'($urandom));
    end
    cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
    check("idle_wea_low", wea, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kmeans_fb_writer.md
Name: kmeans_fb_writer

Overview:
- Upstream stage of the VGA scan-out block.
- Consumes a raster-order stream of k-means cluster labels, one per pixel, and maps each label through a programmable palette to a 12-bit RGB444 colour.
- Writes the colours into port A of the dual-port framebuffer. Port B of that framebuffer is read by the VGA controller at address x + y*640.
- Signals frame completion to the k-means control logic.

Parameters:
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- K, 8, number of clusters / palette entries
- LABEL_W, 3, label width, equal to clog2(K)
- PIX_W, 12, framebuffer word width, {R[3:0],G[3:0],B[3:0]}
- ADDR_W, 19, framebuffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- s_valid  in  1  label beat valid
- s_ready  out  1  block can accept a beat
- s_label  in  LABEL_W  cluster index of the current pixel
- s_sof  in  1  beat is pixel (0,0) of a frame
- pal_we  in  1  palette write strobe
- pal_addr  in  LABEL_W  palette entry to write
- pal_data  in  PIX_W  colour to write
- wea  out  1  framebuffer write enable
- addra  out  ADDR_W  framebuffer write address
- dina  out  PIX_W  framebuffer write data
- frame_done  out  1  one-cycle pulse after the last pixel is written
- busy  out  1  high while in WRITE or DONE
- err_sof  out  1  one-cycle pulse on a framing error

Behaviour:
- Reset is asynchronous and active high. While rst is high, or after it releases:
  - state = IDLE, x = y = 0
  - wea = 0, addra = 0, dina = 0
  - frame_done = 0, err_sof = 0, busy = 0
  - palette loaded with defaults: 0:000, 1:F00, 2:0F0, 3:00F, 4:FF0, 5:0FF, 6:F0F, 7:FFF. If K > 8, entries 8 and above reset to 000.
- A beat is accepted when s_valid && s_ready.
- s_ready = 1 in IDLE and WRITE, 0 in DONE.
- State machine:
  - IDLE: an accepted beat with s_sof=1 is written as pixel 0, then go to WRITE. An accepted beat with s_sof=0 is discarded, err_sof pulses, stay in IDLE.
  - WRITE: each accepted beat is written at the current address, and x/y advance. An accepted beat with s_sof=1 restarts the frame: it is written at address 0, x/y = (1,0), err_sof pulses. When pixel WIDTH*HEIGHT-1 is accepted, go to DONE.
  - DONE: lasts exactly one cycle. frame_done is registered high during this cycle (coincident with the wea of the last pixel). Then return to IDLE.
- Addressing:
  - A linear address counter increments by 1 per accepted beat; no multiplier.
  - Invariant: address = y*WIDTH + x.
  - x wraps at WIDTH-1 to 0 and increments y.
  - The counter never exceeds WIDTH*HEIGHT-1.
- Latency: a beat accepted in cycle n produces wea=1 with its addra/dina in cycle n+1. Outputs are registered.
- wea is 0 in any cycle following a cycle with no accepted beat. addra/dina hold their last values.
- Palette:
  - The write (pal_we) is registered.
  - A beat accepted in the same cycle as a palette write to the same entry uses the old colour. Later beats use the new colour.
  - Palette writes are allowed in every state.
- s_label values >= K map to colour 000.
- Reset mid-frame aborts the frame: no frame_done, the next frame must start with s_sof.
- busy = (state != IDLE).

Optional Feature:
- Macro: KMEANS_FB_GRID_EN.
- Defined: any pixel with x[5:0]==0 or y[5:0]==0 is written as 12'hFFF regardless of label, giving a 64-pixel alignment grid for board bring-up. Latency is unchanged.
- Undefined: palette output only; no grid logic is synthesised.

Decomposition:
- Package kmeans_vga_pkg holds:
  - constants H_ACTIVE=640, V_ACTIVE=480, FB_DEPTH=307200, PIX_W=12, LABEL_W=3, ADDR_W=19
  - the default palette constant array
  - the state enum {IDLE, WRITE, DONE}
- Sub-module kmeans_palette: K x PIX_W register file with async reset to the defaults, one write port and one combinational read port.
- Counters and FSM stay in kmeans_fb_writer.

Test Plan (WIDTH=4, HEIGHT=2 unless noted):
- Reset, then stream 8 beats with labels 0..7, s_sof on the first, s_valid held high. Expect:
  - wea high for 8 cycles
  - addra 0..7, dina 000, F00, 0F0, 00F, FF0, 0FF, F0F, FFF
  - frame_done high in the cycle addra=7
  - s_ready low for that one cycle
- Beat with s_sof=0 while in IDLE -> err_sof pulse, wea stays 0, state remains IDLE.
- In WRITE at address 5, send a beat with s_sof=1 -> err_sof pulse, the beat is written at addra=0, the next beat goes to addra=1.
- In the same cycle, pal_we=1 with pal_addr=2, pal_data=ABC and an accepted beat with label 2 -> that beat writes 0F0. The next label-2 beat writes ABC.
- Assert rst mid-frame at address 3 -> wea, addra, and dina all go to 0 immediately, no frame_done. Palette back to defaults, so a label-2 beat writes 0F0.
- With KMEANS_FB_GRID_EN and default 640x480, stream all label 3 -> addr 0 and addr 64 = FFF, addr 1 = 00F, addr 64*640+1 = FFF.
